// File: rtl/pwm_dead_time_gen.sv
// Complementary half-bridge gate driver with programmable dead time, enable and
// a latched fault shutdown. It consumes the single-ended PWM command from the
// same clock domain.
module pwm_dead_time_gen #(
  parameter int DEAD_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DEAD_W-1:0] dead_cycles,
  input  logic              pwm_in,
  input  logic              fault,
  input  logic              fault_clr,
  output logic              hs_out,
  output logic              ls_out,
  output logic              fault_latched,
  output logic              busy
);

  typedef enum logic [2:0] {OFF, DT_TO_HS, HS_ON, DT_TO_LS, LS_ON} state_t;

  localparam logic [DEAD_W-1:0] CNT_ONE = DEAD_W'(1);

  state_t            state_q, state_d;
  logic [DEAD_W-1:0] cnt_q, cnt_d;
  logic              flt_q, flt_d;
  logic              hs_q, ls_q, busy_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= OFF;
      cnt_q   <= '0;
      flt_q   <= 1'b0;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flt_q   <= flt_d;
      hs_q    <= (state_d == HS_ON);
      ls_q    <= (state_d == LS_ON);
      busy_q  <= (state_d == DT_TO_HS) || (state_d == DT_TO_LS);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flt_d   = flt_q;
    if (fault) begin
      flt_d   = 1'b1;
      state_d = OFF;
      cnt_d   = '0;
    end else begin
      if (fault_clr) flt_d = 1'b0;
      // The exit from OFF waits one edge after a clear because the gate uses the latched value.
      if (flt_q || !enable) begin
        state_d = OFF;
        cnt_d   = '0;
      end else begin
        case (state_q)
          OFF: begin
            state_d = pwm_in ? DT_TO_HS : DT_TO_LS;
            cnt_d   = dead_cycles;
          end
          HS_ON: if (!pwm_in) begin
            state_d = DT_TO_LS;
            cnt_d   = dead_cycles;
          end
          LS_ON: if (pwm_in) begin
            state_d = DT_TO_HS;
            cnt_d   = dead_cycles;
          end
          DT_TO_HS, DT_TO_LS: begin
            // A reversal keeps counting, so the off-time is measured from the last turn-off.
            if (cnt_q == '0) begin
              state_d = pwm_in ? HS_ON : LS_ON;
            end else begin
              state_d = pwm_in ? DT_TO_HS : DT_TO_LS;
              cnt_d   = cnt_q - CNT_ONE;
            end
          end
          default: begin
            state_d = OFF;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  assign hs_out        = hs_q;
  assign ls_out        = ls_q;
  assign busy          = busy_q;
  assign fault_latched = flt_q;

endmodule
